sysid_checker: RTL and testbench

- Avalon-MM read master that sits directly downstream of the system ID slave and consumes its 32-bit readdata.
- After reset, or on command, it reads the ID word (address 0) and the build timestamp word (address 1).
- It compares both words against compile-time expected values and publishes match flags, the captured words and a saturating mismatch counter to the boot/health logic.

---
 rtl/sysid_checker.sv | 213 +++++++++++++++++++++
 tb/tb_sysid_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Purpose : Avalon-MM read master that fetches the sysid ID and timestamp words and checks them.
// Latency : 2*(READ_LATENCY+1)+1 cycles from RD_ID entry to done_pulse; fixed-latency slave, no waitrequest.
// Backpr. : none; start while busy (or in CMP) is dropped, not queued.
// Optional: define SYSID_PERIODIC_CHECK_EN to re-run the check every CHECK_PERIOD idle cycles.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID  = 32'd0,
   parameter logic [31:0] EXPECTED_TS  = 32'd1711549111,
   parameter int          READ_LATENCY = 0,
   parameter int          AUTO_START   = 1,
   parameter int unsigned CHECK_PERIOD = 1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sys_address,
   output logic        sys_read,
   input  logic [31:0] sys_readdata,
   output logic        busy,
   output logic        done,
   output logic        done_pulse,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        id_match,
   output logic        ts_match,
   output logic [7:0]  mismatch_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ID   = 3'd1,
      WAIT_ID = 3'd2,
      RD_TS   = 3'd3,
      WAIT_TS = 3'd4,
      CMP     = 3'd5
   } state_t;

   // Latency is 0..7, so a 3-bit cycle counter is enough.
   localparam logic [2:0] LAT  = 3'(READ_LATENCY);
   localparam logic       AUTO = (AUTO_START != 0);

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  lat_cnt;
   logic [2:0]  lat_cnt_nxt;
   logic        first_cyc;
   logic        done_q;
   logic [31:0] id_q;
   logic [31:0] ts_q;
   logic        id_m_q;
   logic        ts_m_q;
   logic [7:0]  mis_q;
   logic        sample_id;
   logic        sample_ts;
   logic        period_hit;
   logic        trigger;

`ifdef SYSID_PERIODIC_CHECK_EN
   localparam logic [31:0] PERIOD_LAST = 32'(CHECK_PERIOD - 1);

   logic [31:0] period_cnt;

   assign period_hit = (state == IDLE) && done_q && (period_cnt == PERIOD_LAST);

   // Idle-time counter; only runs once a first check has completed.
   always_ff @(posedge clock) begin
      if (reset) begin
         period_cnt <= '0;
      end else if (start || period_hit) begin
         period_cnt <= '0;
      end else if ((state == IDLE) && done_q) begin
         period_cnt <= period_cnt + 32'd1;
      end
   end
`else
   logic unused_period;

   assign period_hit    = 1'b0;
   assign unused_period = |CHECK_PERIOD;
`endif

   // Auto-start fires only in the first cycle with reset low.
   assign trigger = start || (first_cyc && AUTO) || period_hit;

   // First-cycle-after-reset marker for AUTO_START.
   always_ff @(posedge clock) begin
      if (reset) begin
         first_cyc <= 1'b1;
      end else begin
         first_cyc <= 1'b0;
      end
   end

   // State and latency-counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         lat_cnt <= '0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
      end
   end

   // Next-state decode and Moore outputs to the slave and the health logic.
   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      sys_read    = 1'b0;
      sys_address = 1'b0;
      busy        = 1'b0;
      done        = done_q;
      done_pulse  = 1'b0;
      sample_id   = 1'b0;
      sample_ts   = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt = RD_ID;
            end
         end
         RD_ID: begin
            sys_read    = 1'b1;
            busy        = 1'b1;
            lat_cnt_nxt = 3'd1;
            if (LAT == 3'd0) begin
               sample_id = 1'b1;
               state_nxt = RD_TS;
            end else begin
               state_nxt = WAIT_ID;
            end
         end
         WAIT_ID: begin
            busy = 1'b1;
            if (lat_cnt == LAT) begin
               sample_id = 1'b1;
               state_nxt = RD_TS;
            end else begin
               lat_cnt_nxt = lat_cnt + 3'd1;
            end
         end
         RD_TS: begin
            sys_read    = 1'b1;
            sys_address = 1'b1;
            busy        = 1'b1;
            lat_cnt_nxt = 3'd1;
            if (LAT == 3'd0) begin
               sample_ts = 1'b1;
               state_nxt = CMP;
            end else begin
               state_nxt = WAIT_TS;
            end
         end
         WAIT_TS: begin
            sys_address = 1'b1;
            busy        = 1'b1;
            if (lat_cnt == LAT) begin
               sample_ts = 1'b1;
               state_nxt = CMP;
            end else begin
               lat_cnt_nxt = lat_cnt + 3'd1;
            end
         end
         CMP: begin
            busy       = 1'b1;
            done       = 1'b1;
            done_pulse = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture readdata only on the sampling edge of each word.
   always_ff @(posedge clock) begin
      if (reset) begin
         id_q <= '0;
         ts_q <= '0;
      end else begin
         if (sample_id) begin
            id_q <= sys_readdata;
         end
         if (sample_ts) begin
            ts_q <= sys_readdata;
         end
      end
   end

   // Match flags, sticky done and the saturating mismatch counter move only in CMP.
   always_ff @(posedge clock) begin
      if (reset) begin
         id_m_q <= 1'b0;
         ts_m_q <= 1'b0;
         done_q <= 1'b0;
         mis_q  <= '0;
      end else if (state == CMP) begin
         id_m_q <= (id_q == EXPECTED_ID);
         ts_m_q <= (ts_q == EXPECTED_TS);
         done_q <= 1'b1;
         if (((id_q != EXPECTED_ID) || (ts_q != EXPECTED_TS)) && (mis_q != 8'hFF)) begin
            mis_q <= mis_q + 8'd1;
         end
      end
   end

   assign id_value       = id_q;
   assign ts_value       = ts_q;
   assign id_match       = id_m_q;
   assign ts_match       = ts_m_q;
   assign mismatch_count = mis_q;

endmodule

// File: tb/tb_sysid_checker.sv
module tb_sysid_checker;

   localparam logic [31:0] ID_GOOD = 32'd0;
   localparam logic [31:0] TS_GOOD = 32'd1711549111;
   localparam logic [31:0] TS_BAD  = 32'h12345678;
   localparam logic [31:0] JUNK    = 32'hDEADBEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // ---------------- instance 0: READ_LATENCY=0 ----------------
   logic rst0, start0, addr0, read0, busy0, done0, pulse0, idm0, tsm0;
   logic [31:0] rdata0, idv0, tsv0, ts_word0;
   logic [7:0] cnt0;
   assign rdata0 = read0 ? (addr0 ? ts_word0 : ID_GOOD) : JUNK;

   sysid_checker #(.READ_LATENCY(0)) u0 (
      .clock(clk), .reset(rst0), .start(start0),
      .sys_address(addr0), .sys_read(read0), .sys_readdata(rdata0),
      .busy(busy0), .done(done0), .done_pulse(pulse0),
      .id_value(idv0), .ts_value(tsv0), .id_match(idm0), .ts_match(tsm0),
      .mismatch_count(cnt0));

   // ---------------- instance 2: READ_LATENCY=2 ----------------
   logic rst2, start2, addr2, read2, busy2, done2, pulse2, idm2, tsm2;
   logic [31:0] rdata2, idv2, tsv2;
   logic [7:0] cnt2;
   logic [1:0] v2_sr = '0;
   logic [1:0] a2_sr = '0;
   always @(posedge clk) begin
      v2_sr <= {v2_sr[0], read2};
      a2_sr <= {a2_sr[0], addr2};
   end
   assign rdata2 = v2_sr[1] ? (a2_sr[1] ? TS_GOOD : ID_GOOD) : JUNK;

   sysid_checker #(.READ_LATENCY(2), .CHECK_PERIOD(16)) u2 (
      .clock(clk), .reset(rst2), .start(start2),
      .sys_address(addr2), .sys_read(read2), .sys_readdata(rdata2),
      .busy(busy2), .done(done2), .done_pulse(pulse2),
      .id_value(idv2), .ts_value(tsv2), .id_match(idm2), .ts_match(tsm2),
      .mismatch_count(cnt2));

   // ---------------- instance 3: READ_LATENCY=3 ----------------
   logic rst3, start3, addr3, read3, busy3, done3, pulse3, idm3, tsm3;
   logic [31:0] rdata3, idv3, tsv3, ts_word3;
   logic [7:0] cnt3;
   logic [2:0] v3_sr = '0;
   logic [2:0] a3_sr = '0;
   always @(posedge clk) begin
      v3_sr <= {v3_sr[1:0], read3};
      a3_sr <= {a3_sr[1:0], addr3};
   end
   assign rdata3 = v3_sr[2] ? (a3_sr[2] ? ts_word3 : ID_GOOD) : JUNK;

   sysid_checker #(.READ_LATENCY(3)) u3 (
      .clock(clk), .reset(rst3), .start(start3),
      .sys_address(addr3), .sys_read(read3), .sys_readdata(rdata3),
      .busy(busy3), .done(done3), .done_pulse(pulse3),
      .id_value(idv3), .ts_value(tsv3), .id_match(idm3), .ts_match(tsm3),
      .mismatch_count(cnt3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One start-triggered check on instance 0; entered and left at a negedge in IDLE.
   task automatic run_check0();
      int t;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      t = 0;
      while (!pulse0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!pulse0) check("run_check0_timeout", 32'(pulse0), 32'd1);
      @(negedge clk);
   endtask

   typedef struct {
      logic       rst;
      logic       start;
      logic       bad_ts;
      logic       rd;
      logic       addr;
      logic       busy;
      logic       done;
      logic       pulse;
      logic       idm;
      logic       tsm;
      logic [7:0] cnt;
      logic [31:0] tsv;
   } vec_t;

   vec_t vecs[15];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
      start0 = 1'b0; start2 = 1'b0; start3 = 1'b0;
      ts_word0 = TS_GOOD;
      ts_word3 = 32'hCAFEF00D;

      //            rst start bad  rd addr busy done pls idm tsm cnt  ts_value
      vecs[0]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0, 32'd0};
      vecs[1]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0, 32'd0};
      vecs[2]  = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 32'd0};
      vecs[3]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 32'd0};
      vecs[4]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,8'd0, TS_GOOD};
      vecs[5]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'd0, TS_GOOD};
      vecs[6]  = '{1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,8'd0, TS_GOOD};
      vecs[7]  = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,8'd0, TS_GOOD};
      vecs[8]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,8'd0, TS_GOOD};
      vecs[9]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'd0, TS_GOOD};
      vecs[10] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,8'd0, TS_GOOD};
      vecs[11] = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,8'd0, TS_GOOD};
      vecs[12] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,8'd0, TS_BAD};
      vecs[13] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'd1, TS_BAD};
      vecs[14] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'd1, TS_BAD};

      repeat (3) @(negedge clk);

      // Cycle-by-cycle vectors on instance 0: auto-start, start handling, mismatch.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         rst0     = vecs[i].rst;
         start0   = vecs[i].start;
         ts_word0 = vecs[i].bad_ts ? TS_BAD : TS_GOOD;
         check($sformatf("v%0d_read", i),  32'(read0),  32'(vecs[i].rd));
         check($sformatf("v%0d_addr", i),  32'(addr0),  32'(vecs[i].addr));
         check($sformatf("v%0d_busy", i),  32'(busy0),  32'(vecs[i].busy));
         check($sformatf("v%0d_done", i),  32'(done0),  32'(vecs[i].done));
         check($sformatf("v%0d_pulse", i), 32'(pulse0), 32'(vecs[i].pulse));
         check($sformatf("v%0d_idm", i),   32'(idm0),   32'(vecs[i].idm));
         check($sformatf("v%0d_tsm", i),   32'(tsm0),   32'(vecs[i].tsm));
         check($sformatf("v%0d_cnt", i),   32'(cnt0),   32'(vecs[i].cnt));
         check($sformatf("v%0d_idv", i),   idv0,        ID_GOOD);
         check($sformatf("v%0d_tsv", i),   tsv0,        vecs[i].tsv);
      end

      // Three mismatching checks in total, then saturation after 260.
      run_check0();
      run_check0();
      check("mis3_cnt", 32'(cnt0), 32'd3);
      check("mis3_idm", 32'(idm0), 32'd1);
      check("mis3_tsm", 32'(tsm0), 32'd0);
      for (int i = 0; i < 257; i++) run_check0();
      check("sat_cnt", 32'(cnt0), 32'd255);

      // start held high for 12 cycles from IDLE: three back-to-back checks, one read pair each.
      begin
         int n_rd = 0;
         int n_pl = 0;
         start0 = 1'b1;
         for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (read0) n_rd++;
            if (pulse0) n_pl++;
         end
         start0 = 1'b0;
         check("hold_start_reads", 32'(n_rd), 32'd6);
         check("hold_start_pulses", 32'(n_pl), 32'd3);
         repeat (2) @(negedge clk);
         check("sat_cnt_after", 32'(cnt0), 32'd255);
      end

      // Instance 2: READ_LATENCY=2 timing from reset release.
      begin
         int n_rd = 0;
         int rd1 = -1;
         int rd2 = -1;
         int rd3 = -1;
         int pl = -1;
         logic a1 = 1'b0;
         logic a2 = 1'b0;
         logic a_k2 = 1'b1;
         logic a_k5 = 1'b0;
         logic b7 = 1'b0;
         logic b8 = 1'b1;
         rst2 = 1'b0;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (read2) begin
               n_rd++;
               if (n_rd == 1) begin rd1 = k; a1 = addr2; end
               if (n_rd == 2) begin rd2 = k; a2 = addr2; end
               if (n_rd == 3) rd3 = k;
            end
            if (pulse2 && pl < 0) pl = k;
            if (k == 2) a_k2 = addr2;
            if (k == 5) a_k5 = addr2;
            if (k == 7) b7 = busy2;
            if (k == 8) begin
               b8 = busy2;
               check("l2_idv", idv2, ID_GOOD);
               check("l2_tsv", tsv2, TS_GOOD);
               check("l2_idm", 32'(idm2), 32'd1);
               check("l2_tsm", 32'(tsm2), 32'd1);
               check("l2_cnt", 32'(cnt2), 32'd0);
               check("l2_done", 32'(done2), 32'd1);
            end
         end
         check("l2_rd1_cycle", 32'(rd1), 32'd1);
         check("l2_rd1_addr", 32'(a1), 32'd0);
         check("l2_rd2_cycle", 32'(rd2), 32'd4);
         check("l2_rd2_addr", 32'(a2), 32'd1);
         check("l2_waitid_addr", 32'(a_k2), 32'd0);
         check("l2_waitts_addr", 32'(a_k5), 32'd1);
         check("l2_pulse_cycle", 32'(pl), 32'd7);
         check("l2_busy_cmp", 32'(b7), 32'd1);
         check("l2_busy_after", 32'(b8), 32'd0);
`ifdef SYSID_PERIODIC_CHECK_EN
         check("l2_periodic_rd", 32'(rd3), 32'd24);
         check("l2_read_count", 32'(n_rd), 32'd4);
`else
         check("l2_no_rerun_rd", 32'(rd3), 32'hFFFFFFFF);
         check("l2_read_count", 32'(n_rd), 32'd2);
`endif
      end

      // Instance 3: READ_LATENCY=3, reset in WAIT_TS aborts the check.
      begin
         int t;
         rst3 = 1'b0;
         t = 0;
         while (!pulse3 && t < 30) begin @(negedge clk); t++; end
         check("l3_first_pulse_cycle", 32'(t), 32'd9);
         @(negedge clk);
         check("l3_first_cnt", 32'(cnt3), 32'd1);
         check("l3_first_tsm", 32'(tsm3), 32'd0);
         check("l3_first_tsv", tsv3, 32'hCAFEF00D);
         ts_word3 = TS_GOOD;
         start3 = 1'b1;
         @(negedge clk);
         start3 = 1'b0;
         t = 0;
         while (!(read3 && addr3) && t < 30) begin @(negedge clk); t++; end
         check("l3_rdts_seen", 32'(read3 && addr3), 32'd1);
         @(negedge clk);
         check("l3_waitts_busy", 32'(busy3), 32'd1);
         check("l3_waitts_read", 32'(read3), 32'd0);
         check("l3_waitts_addr", 32'(addr3), 32'd1);
         rst3 = 1'b1;
         @(negedge clk);
         check("l3_rst_read", 32'(read3), 32'd0);
         check("l3_rst_addr", 32'(addr3), 32'd0);
         check("l3_rst_busy", 32'(busy3), 32'd0);
         check("l3_rst_done", 32'(done3), 32'd0);
         check("l3_rst_pulse", 32'(pulse3), 32'd0);
         check("l3_rst_idv", idv3, 32'd0);
         check("l3_rst_tsv", tsv3, 32'd0);
         check("l3_rst_idm", 32'(idm3), 32'd0);
         check("l3_rst_tsm", 32'(tsm3), 32'd0);
         check("l3_rst_cnt", 32'(cnt3), 32'd0);
         rst3 = 1'b0;
         t = 0;
         while (!pulse3 && t < 30) begin @(negedge clk); t++; end
         check("l3_rerun_pulse_cycle", 32'(t), 32'd9);
         @(negedge clk);
         check("l3_rerun_tsv", tsv3, TS_GOOD);
         check("l3_rerun_idv", idv3, ID_GOOD);
         check("l3_rerun_idm", 32'(idm3), 32'd1);
         check("l3_rerun_tsm", 32'(tsm3), 32'd1);
         check("l3_rerun_cnt", 32'(cnt3), 32'd0);
         check("l3_rerun_done", 32'(done3), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
